// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM port bundle for mem_port_arbiter.
// err exists only when MEM_ARB_RANGE_CHECK_EN is defined.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    localparam int MW = DW / 8;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic [MW-1:0] ls_we_mask;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    logic          dbg_req;
    logic [MW-1:0] dbg_we_mask;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic [MW-1:0] mem_wr_mask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic          busy;
`ifdef MEM_ARB_RANGE_CHECK_EN
    logic          err;
`endif

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we_mask, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        input  dbg_req, dbg_we_mask, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_wr_mask, mem_addr, mem_din,
        input  mem_dout,
`ifdef MEM_ARB_RANGE_CHECK_EN
        output err,
`endif
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we_mask, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        output dbg_req, dbg_we_mask, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_wr_mask, mem_addr, mem_din,
        output mem_dout,
`ifdef MEM_ARB_RANGE_CHECK_EN
        input  err,
`endif
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way (DBG > LS > IF) arbiter for a single-port masked sync RAM.
// Optional address range check: define MEM_ARB_RANGE_CHECK_EN.
module mem_port_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int MW = DW / 8;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {P_NONE, P_IF, P_LS, P_DBG} port_t;

    state_t        state_q;
    port_t         port_q;
    port_t         win;
    logic [AW-1:0] addr_q;
    logic [MW-1:0] mask_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    starve_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] ls_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic [AW-1:0] nxt_addr;
    logic [MW-1:0] nxt_mask;
    logic [DW-1:0] nxt_wdata;
    logic          oob;
    logic          is_wr;
    logic          in_acc;
    logic          in_resp;
    logic [DW-1:0] rd_val;

`ifdef MEM_ARB_RANGE_CHECK_EN
    assign oob = 32'(addr_q) >= 32'(MEM_WORDS);
`else
    assign oob = 1'b0;
`endif

    assign is_wr   = |mask_q;
    assign in_acc  = state_q == ACCESS;
    assign in_resp = state_q == RESP;
    assign rd_val  = oob ? '0 : bus.mem_dout;

    // IF overrides LS once it has lost LIMIT arbitrations in a row
    always_comb begin
        win = P_NONE;
        if (!rst && state_q == IDLE) begin
            if (bus.dbg_req)
                win = P_DBG;
            else if (bus.ls_req &&
                     !(bus.if_req && starve_q == LIMIT))
                win = P_LS;
            else if (bus.if_req)
                win = P_IF;
        end
    end

    always_comb begin
        nxt_addr  = addr_q;
        nxt_mask  = '0;
        nxt_wdata = wdata_q;
        case (win)
            P_DBG: begin
                nxt_addr  = bus.dbg_addr;
                nxt_mask  = bus.dbg_we_mask;
                nxt_wdata = bus.dbg_wdata;
            end
            P_LS: begin
                nxt_addr  = bus.ls_addr;
                nxt_mask  = bus.ls_we_mask;
                nxt_wdata = bus.ls_wdata;
            end
            P_IF: nxt_addr = bus.if_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            port_q      <= P_NONE;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (win != P_NONE) begin
                    port_q  <= win;
                    addr_q  <= nxt_addr;
                    mask_q  <= nxt_mask;
                    wdata_q <= nxt_wdata;
                    state_q <= ACCESS;
                    if (win == P_IF)
                        starve_q <= '0;
                    else if (win == P_LS && bus.if_req &&
                             starve_q != 8'hFF)
                        starve_q <= starve_q + 8'd1;
                end
                ACCESS: state_q <= is_wr ? IDLE : RESP;
                RESP: begin
                    case (port_q)
                        P_IF:  if_rdata_q  <= rd_val;
                        P_LS:  ls_rdata_q  <= rd_val;
                        P_DBG: dbg_rdata_q <= rd_val;
                        default: ;
                    endcase
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt  = win == P_IF;
    assign bus.ls_gnt  = win == P_LS;
    assign bus.dbg_gnt = win == P_DBG;
    assign bus.busy    = state_q != IDLE || win != P_NONE;

    assign bus.if_rvalid  = in_resp && !oob && port_q == P_IF;
    assign bus.ls_rvalid  = in_resp && !oob && port_q == P_LS;
    assign bus.dbg_rvalid = in_resp && !oob && port_q == P_DBG;

    // read data appears in the rvalid cycle, then the register holds it
    assign bus.if_rdata =
        (in_resp && port_q == P_IF) ? rd_val : if_rdata_q;
    assign bus.ls_rdata =
        (in_resp && port_q == P_LS) ? rd_val : ls_rdata_q;
    assign bus.dbg_rdata =
        (in_resp && port_q == P_DBG) ? rd_val : dbg_rdata_q;

    assign bus.mem_en      = in_acc && !oob;
    assign bus.mem_wr_mask = (in_acc && !oob) ? mask_q : '0;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_din     = wdata_q;

`ifdef MEM_ARB_RANGE_CHECK_EN
    assign bus.err = oob && ((in_acc && is_wr) || in_resp);
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Drives at posedge+1, samples at posedge+2.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam int WORDS = 512;
`else
    localparam int WORDS = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] ram [0:1023];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW),
        .MEM_WORDS(WORDS), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr_mask == 4'b0)
                bus.mem_dout <= ram[bus.mem_addr];
            else
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wr_mask[b])
                        ram[bus.mem_addr][8*b +: 8] <=
                            bus.mem_din[8*b +: 8];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy got=%b exp=0", bus.busy);
        end
        total++;
        if (bus.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en);
        end
        total++;
        if ({bus.if_gnt, bus.ls_gnt, bus.dbg_gnt} !== 3'b0) begin
            bad++;
            $display("FAIL rst_gnt got=%b exp=000",
                     {bus.if_gnt, bus.ls_gnt, bus.dbg_gnt});
        end
        total++;
        if (bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_rdata got=%h/%h exp=0",
                     bus.if_rdata, bus.ls_rdata);
        end
    endtask

    task automatic test_if_read();
        cyc();
        bus.if_req = 1'b1;
        bus.if_addr = 10'h004;
        #1;
        total++;
        if (bus.if_gnt !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL if_c0 gnt=%b busy=%b exp=1/1",
                     bus.if_gnt, bus.busy);
        end
        cyc();
        bus.if_req = 1'b0;
        #1;
        total++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'h004 ||
            bus.mem_wr_mask !== 4'h0) begin
            bad++;
            $display("FAIL if_c1 en=%b addr=%h mask=%h exp=1/004/0",
                     bus.mem_en, bus.mem_addr, bus.mem_wr_mask);
        end
        cyc();
        #1;
        total++;
        if (bus.if_rvalid !== 1'b1 ||
            bus.if_rdata !== 32'h00100093 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL if_c2 rv=%b data=%h busy=%b exp=1/00100093/1",
                     bus.if_rvalid, bus.if_rdata, bus.busy);
        end
        cyc();
        #1;
        total++;
        if (bus.if_rvalid !== 1'b0 ||
            bus.if_rdata !== 32'h00100093 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL if_c3 rv=%b data=%h busy=%b exp=0/00100093/0",
                     bus.if_rvalid, bus.if_rdata, bus.busy);
        end
    endtask

    task automatic test_ls_mask();
        cyc();
        bus.ls_req = 1'b1;
        bus.ls_we_mask = 4'b0011;
        bus.ls_addr = 10'h010;
        bus.ls_wdata = 32'hAABBCCDD;
        #1;
        total++;
        if (bus.ls_gnt !== 1'b1) begin
            bad++;
            $display("FAIL lsw_gnt got=%b exp=1", bus.ls_gnt);
        end
        cyc();
        bus.ls_req = 1'b0;
        #1;
        total++;
        if (bus.mem_en !== 1'b1 || bus.mem_wr_mask !== 4'b0011 ||
            bus.mem_din !== 32'hAABBCCDD) begin
            bad++;
            $display("FAIL lsw_acc en=%b mask=%b din=%h exp=1/0011/aabbccdd",
                     bus.mem_en, bus.mem_wr_mask, bus.mem_din);
        end
        cyc();
        #1;
        total++;
        if (bus.ls_rvalid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL lsw_done rv=%b busy=%b exp=0/0",
                     bus.ls_rvalid, bus.busy);
        end
        bus.ls_req = 1'b1;
        bus.ls_we_mask = 4'b0000;
        #1;
        total++;
        if (bus.ls_gnt !== 1'b1) begin
            bad++;
            $display("FAIL lsr_gnt got=%b exp=1", bus.ls_gnt);
        end
        cyc();
        bus.ls_req = 1'b0;
        #1;
        cyc();
        #1;
        total++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h1122CCDD) begin
            bad++;
            $display("FAIL lsr_data rv=%b data=%h exp=1/1122ccdd",
                     bus.ls_rvalid, bus.ls_rdata);
        end
        cyc();
        #1;
        total++;
        if (bus.ls_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL lsr_pulse rv=%b exp=0", bus.ls_rvalid);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_g [3];
        logic [31:0] exp_d [3];
        logic [2:0] g;
        logic rv;
        logic [31:0] d;
        exp_g[0] = 3'b100; exp_d[0] = 32'hD0D0_0032;
        exp_g[1] = 3'b010; exp_d[1] = 32'h5151_0031;
        exp_g[2] = 3'b001; exp_d[2] = 32'h1F1F_0030;
        cyc();
        bus.if_addr = 10'h030;
        bus.ls_addr = 10'h031;
        bus.ls_we_mask = 4'h0;
        bus.dbg_addr = 10'h032;
        bus.dbg_we_mask = 4'h0;
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        bus.dbg_req = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            g = 3'b0;
            for (int i = 0; i < 8; i++) begin
                g = {bus.dbg_gnt, bus.ls_gnt, bus.if_gnt};
                if (g != 3'b0) break;
                cyc();
                #1;
            end
            total++;
            if (g !== exp_g[k]) begin
                bad++;
                $display("FAIL prio_gnt%0d got=%b exp=%b", k, g, exp_g[k]);
            end
            cyc();
            if (g[2]) bus.dbg_req = 1'b0;
            if (g[1]) bus.ls_req = 1'b0;
            if (g[0]) bus.if_req = 1'b0;
            #1;
            cyc();
            #1;
            rv = exp_g[k][2] ? bus.dbg_rvalid :
                 exp_g[k][1] ? bus.ls_rvalid : bus.if_rvalid;
            d = exp_g[k][2] ? bus.dbg_rdata :
                exp_g[k][1] ? bus.ls_rdata : bus.if_rdata;
            total++;
            if (rv !== 1'b1 || d !== exp_d[k]) begin
                bad++;
                $display("FAIL prio_rd%0d rv=%b data=%h exp=1/%h",
                         k, rv, d, exp_d[k]);
            end
            cyc();
            #1;
        end
    endtask

    task automatic test_starve();
        logic [1:0] g;
        logic [1:0] exp;
        bus.if_addr = 10'h040;
        bus.ls_addr = 10'h041;
        bus.ls_we_mask = 4'h0;
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            exp = (k == 8) ? 2'b01 : 2'b10;
            g = 2'b0;
            for (int i = 0; i < 8; i++) begin
                g = {bus.ls_gnt, bus.if_gnt};
                if (g != 2'b0) break;
                cyc();
                #1;
            end
            total++;
            if (g !== exp) begin
                bad++;
                $display("FAIL starve_arb%0d got=%b exp=%b", k, g, exp);
            end
            cyc();
            #1;
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        cyc();
        cyc();
        cyc();
        #1;
    endtask

    task automatic test_reset_mid();
        logic seen;
        cyc();
        bus.ls_req = 1'b1;
        bus.ls_we_mask = 4'h0;
        bus.ls_addr = 10'h020;
        #1;
        total++;
        if (bus.ls_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rmid_gnt got=%b exp=1", bus.ls_gnt);
        end
        cyc();
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 ||
            bus.ls_gnt !== 1'b0 || bus.mem_addr !== 10'h0 ||
            bus.ls_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rmid_zero en=%b busy=%b gnt=%b addr=%h exp=0",
                     bus.mem_en, bus.busy, bus.ls_gnt, bus.mem_addr);
        end
        seen = 1'b0;
        cyc();
        seen = seen | bus.ls_rvalid;
        cyc();
        seen = seen | bus.ls_rvalid;
        rst = 1'b0;
        #1;
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rmid_rvalid got=%b exp=0", seen);
        end
        total++;
        if (bus.ls_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rmid_first got=%b exp=1", bus.ls_gnt);
        end
        cyc();
        bus.ls_req = 1'b0;
        #1;
        cyc();
        #1;
        total++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hCAFE_0020) begin
            bad++;
            $display("FAIL rmid_read rv=%b data=%h exp=1/cafe0020",
                     bus.ls_rvalid, bus.ls_rdata);
        end
        cyc();
        #1;
    endtask

`ifdef MEM_ARB_RANGE_CHECK_EN
    task automatic test_range();
        cyc();
        bus.dbg_req = 1'b1;
        bus.dbg_we_mask = 4'h0;
        bus.dbg_addr = 10'h200;
        #1;
        total++;
        if (bus.dbg_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rng_gnt got=%b exp=1", bus.dbg_gnt);
        end
        cyc();
        bus.dbg_req = 1'b0;
        #1;
        total++;
        if (bus.mem_en !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL rng_acc en=%b err=%b exp=0/0",
                     bus.mem_en, bus.err);
        end
        cyc();
        #1;
        total++;
        if (bus.err !== 1'b1 || bus.dbg_rvalid !== 1'b0 ||
            bus.dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rng_resp err=%b rv=%b data=%h exp=1/0/0",
                     bus.err, bus.dbg_rvalid, bus.dbg_rdata);
        end
        cyc();
        #1;
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL rng_pulse err=%b exp=0", bus.err);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[10'h004] = 32'h00100093;
        ram[10'h010] = 32'h11223344;
        ram[10'h020] = 32'hCAFE_0020;
        ram[10'h030] = 32'h1F1F_0030;
        ram[10'h031] = 32'h5151_0031;
        ram[10'h032] = 32'hD0D0_0032;
        ram[10'h040] = 32'h0000_0040;
        ram[10'h041] = 32'h0000_0041;
        bus.mem_dout = 32'h0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.ls_req = 1'b0;
        bus.ls_we_mask = '0;
        bus.ls_addr = '0;
        bus.ls_wdata = '0;
        bus.dbg_req = 1'b0;
        bus.dbg_we_mask = '0;
        bus.dbg_addr = '0;
        bus.dbg_wdata = '0;
        test_reset();
        test_if_read();
        test_ls_mask();
        test_priority();
        test_starve();
`ifdef MEM_ARB_RANGE_CHECK_EN
        test_range();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
